// File: rtl/kernel_cc_start_pkg.sv
// Shared types and constants for the kernel_cc start-token consumer/producer.
//   start_state_t   : consumer FSM states
//   DONE_CNT_W      : width of the completion counter
//   TOKEN_W_DEFAULT : default start-token width
package kernel_cc_start_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } start_state_t;

  localparam int unsigned DONE_CNT_W      = 32;
  localparam int unsigned TOKEN_W_DEFAULT = 1;

endpackage

// File: rtl/kernel_cc_start_consumer_if.sv
// FIFO read port and ap_start/ap_ready/ap_done handshake of the start consumer.
//   master : environment side (drives FIFO status/head and process handshake)
//   slave  : consumer side (drives pop strobe and ap_start)
interface kernel_cc_start_consumer_if
  import kernel_cc_start_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TOKEN_W_DEFAULT
);

  logic                  if_empty_n;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_read;
  logic                  if_read_ce;
  logic                  proc_start;
  logic                  proc_ready;
  logic                  proc_done;

  modport master (
    output if_empty_n, if_dout, proc_ready, proc_done,
    input  if_read, if_read_ce, proc_start
  );

  modport slave (
    input  if_empty_n, if_dout, proc_ready, proc_done,
    output if_read, if_read_ce, proc_start
  );

endinterface

// File: rtl/kernel_cc_start_consumer_inflight_cnt.sv
// Up/down counter of accepted-but-not-done iterations.
//   inc/dec   : accept / completion events (simultaneous events cancel)
//   count     : current count, never exceeds MAX, never wraps below 0
//   below_max : count < MAX, gates further accepts
//   underflow : dec without inc while count == 0
module kernel_cc_start_inflight_cnt
  import kernel_cc_start_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         below_max,
  output logic         underflow
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count     = count_q;
  assign below_max = (count_q < W'(MAX));
  assign underflow = dec & ~inc & (count_q == '0);

  // Saturating next count
  always_comb begin
    count_d = count_q;
    if (inc && !dec && below_max) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/kernel_cc_start_consumer.sv
// Read-side controller of the kernel_cc start-token FIFO. Pops one token per
// iteration, latches it, and drives ap_start of the downstream process while
// bounding the number of outstanding iterations.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : FIFO read port + process handshake (slave modport)
//   token        : token of the armed or most recent iteration
//   inflight     : accepted iterations not yet done
//   done_cnt     : total completion pulses, wraps modulo 2^32
//   idle         : nothing armed, nothing in flight, FIFO empty
//   err          : sticky, completion seen with nothing in flight
module kernel_cc_start_consumer
  import kernel_cc_start_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = TOKEN_W_DEFAULT,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  kernel_cc_start_consumer_if.slave bus,
  output logic [DATA_WIDTH-1:0] token,
  output logic [CNT_WIDTH-1:0]  inflight,
  output logic [DONE_CNT_W-1:0] done_cnt,
  output logic                  idle,
  output logic                  err
);

  start_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   token_q, token_d;
  logic                    proc_start_q, proc_start_d;
  logic [DONE_CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    rd;
  logic                    below_max;
  logic                    underflow;
  logic [CNT_WIDTH-1:0]    cnt;

  // Accept only counts while armed; a stray ready in IDLE is ignored
  assign accept = (state_q == ARMED) & bus.proc_ready;
  assign rd     = (state_q == IDLE) & bus.if_empty_n & below_max;

  kernel_cc_start_inflight_cnt #(
    .MAX (MAX_INFLIGHT),
    .W   (CNT_WIDTH)
  ) u_inflight_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (accept),
    .dec       (bus.proc_done),
    .count     (cnt),
    .below_max (below_max),
    .underflow (underflow)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    token_d    = token_q;
    done_cnt_d = done_cnt_q + DONE_CNT_W'(bus.proc_done);
    err_d      = err_q | underflow;
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          token_d = bus.if_dout;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.proc_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    proc_start_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      token_q      <= '0;
      proc_start_q <= 1'b0;
      done_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      token_q      <= token_d;
      proc_start_q <= proc_start_d;
      done_cnt_q   <= done_cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.if_read    = rd;
  assign bus.if_read_ce = 1'b1;
  assign bus.proc_start = proc_start_q;
  assign token          = token_q;
  assign inflight       = cnt;
  assign done_cnt       = done_cnt_q;
  assign err            = err_q;
  assign idle           = (state_q == IDLE) & (cnt == '0) & ~bus.if_empty_n;

endmodule
